// File: rtl/nm_frame_counter_if.sv
// Signal bundle between the MDLL select logic and the frame counter stage.
// The master requests ratios and run state; the slave reports counters, decodes and active ratios.
interface nm_frame_counter_if;
    logic       en;
    logic [3:0] N;
    logic [1:0] M;
    logic [3:0] N_counter;
    logic [1:0] M_counter;
    logic       DIV_N;
    logic       DIV_M;
    logic [3:0] N_act;
    logic [1:0] M_act;
    logic       cfg_upd;

    modport master (
        output en, N, M,
        input  N_counter, M_counter, DIV_N, DIV_M, N_act, M_act, cfg_upd
    );

    modport slave (
        input  en, N, M,
        output N_counter, M_counter, DIV_N, DIV_M, N_act, M_act, cfg_upd
    );
endinterface

// File: rtl/nm_frame_counter.sv
// Nested N x M frame counter on clk_out; divide ratios are latched only at frame boundaries
// so the downstream select logic never sees a counter glitch mid-frame.
module nm_frame_counter (
    input  logic                 clk_out,
    input  logic                 rst_n,
    nm_frame_counter_if.slave    bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [3:0] n_cnt_q, n_cnt_d;
    logic [1:0] m_cnt_q, m_cnt_d;
    logic [3:0] n_act_q, n_act_d;
    logic [1:0] m_act_q, m_act_d;
    logic       cfg_upd_q, cfg_upd_d;

    logic [3:0] n_safe;
    logic [1:0] m_safe;
    logic       n_last;
    logic       m_last;
    logic       cfg_diff;

    // A requested ratio of 0 behaves as 1 so the counters always have a reachable terminal value.
    assign n_safe   = (bus.N == 4'd0) ? 4'd1 : bus.N;
    assign m_safe   = (bus.M == 2'd0) ? 2'd1 : bus.M;
    assign cfg_diff = (n_safe != n_act_q) || (m_safe != m_act_q);

    assign n_last = (n_cnt_q == n_act_q);
    assign m_last = (m_cnt_q == m_act_q);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_cnt_q   <= 4'd0;
            m_cnt_q   <= 2'd0;
            n_act_q   <= 4'd0;
            m_act_q   <= 2'd0;
            cfg_upd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_cnt_q   <= n_cnt_d;
            m_cnt_q   <= m_cnt_d;
            n_act_q   <= n_act_d;
            m_act_q   <= m_act_d;
            cfg_upd_q <= cfg_upd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_cnt_d   = n_cnt_q;
        m_cnt_d   = m_cnt_q;
        n_act_d   = n_act_q;
        m_act_d   = m_act_q;
        cfg_upd_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d   = RUN;
                    n_cnt_d   = 4'd1;
                    m_cnt_d   = 2'd1;
                    n_act_d   = n_safe;
                    m_act_d   = m_safe;
                    cfg_upd_d = cfg_diff;
                end
            end
            RUN: begin
                if (!n_last) begin
                    n_cnt_d = n_cnt_q + 4'd1;
                end else if (!m_last) begin
                    n_cnt_d = 4'd1;
                    m_cnt_d = m_cnt_q + 2'd1;
                end else if (bus.en) begin
                    // Frame boundary: the only point where en is honoured and ratios may change.
                    n_cnt_d   = 4'd1;
                    m_cnt_d   = 2'd1;
                    n_act_d   = n_safe;
                    m_act_d   = m_safe;
                    cfg_upd_d = cfg_diff;
                end else begin
                    state_d = IDLE;
                    n_cnt_d = 4'd0;
                    m_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                n_cnt_d = 4'd0;
                m_cnt_d = 2'd0;
            end
        endcase
    end

    assign bus.N_counter = n_cnt_q;
    assign bus.M_counter = m_cnt_q;
    assign bus.DIV_N     = (state_q == RUN) && n_last;
    assign bus.DIV_M     = (state_q == RUN) && n_last && m_last;
    assign bus.N_act     = n_act_q;
    assign bus.M_act     = m_act_q;
    assign bus.cfg_upd   = cfg_upd_q;

endmodule

// File: tb/tb_nm_frame_counter.sv
// Directed plus randomized bench for nm_frame_counter, checked against a frame-position model
// that tracks where in the N_act x M_act frame the counter should be.
module tb_nm_frame_counter;

    logic clk_out;
    logic rst_n;
    int   assertions;
    int   failures;

    nm_frame_counter_if bus ();

    nm_frame_counter dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    // Reference model: running flag, linear position inside the frame, and latched ratios.
    bit mdl_run;
    int mdl_pos;
    int mdl_nact;
    int mdl_mact;
    bit mdl_cfg;

    function automatic void model_reset();
        mdl_run  = 1'b0;
        mdl_pos  = 0;
        mdl_nact = 0;
        mdl_mact = 0;
        mdl_cfg  = 1'b0;
    endfunction

    function automatic void model_load(int n, int m);
        int ns;
        int ms;
        ns = (n == 0) ? 1 : n;
        ms = (m == 0) ? 1 : m;
        mdl_cfg  = (ns != mdl_nact) || (ms != mdl_mact);
        mdl_nact = ns;
        mdl_mact = ms;
        mdl_pos  = 0;
    endfunction

    function automatic void model_edge(bit e, int n, int m);
        mdl_cfg = 1'b0;
        if (!mdl_run) begin
            if (e) begin
                mdl_run = 1'b1;
                model_load(n, m);
            end
        end else if (mdl_pos == mdl_nact * mdl_mact - 1) begin
            if (e) model_load(n, m);
            else   mdl_run = 1'b0;
        end else begin
            mdl_pos++;
        end
    endfunction

    task automatic check_val(string tag, logic [7:0] obs, logic [7:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        int exp_n;
        int exp_m;
        bit exp_dn;
        bit exp_dm;
        exp_n  = mdl_run ? (mdl_pos % mdl_nact) + 1 : 0;
        exp_m  = mdl_run ? (mdl_pos / mdl_nact) + 1 : 0;
        exp_dn = mdl_run && ((mdl_pos % mdl_nact) == mdl_nact - 1);
        exp_dm = mdl_run && (mdl_pos == mdl_nact * mdl_mact - 1);
        check_val("N_counter", 8'(bus.N_counter), 8'(exp_n));
        check_val("M_counter", 8'(bus.M_counter), 8'(exp_m));
        check_val("DIV_N",     8'(bus.DIV_N),     8'(exp_dn));
        check_val("DIV_M",     8'(bus.DIV_M),     8'(exp_dm));
        check_val("N_act",     8'(bus.N_act),     8'(mdl_nact));
        check_val("M_act",     8'(bus.M_act),     8'(mdl_mact));
        check_val("cfg_upd",   8'(bus.cfg_upd),   8'(mdl_cfg));
    endtask

    // Drive inputs at the falling edge, let one rising edge act, then compare at the next falling edge.
    task automatic apply_stimulus(bit e, int n, int m);
        bus.en = e;
        bus.N  = 4'(n);
        bus.M  = 2'(m);
        @(posedge clk_out);
        model_edge(e, n, m);
        @(negedge clk_out);
        check_output();
    endtask

    initial begin
        int exp_n_seq [9];
        int exp_m_seq [9];
        int exp_dn_seq[9];
        int exp_dm_seq[9];
        int exp_cfg_seq[9];

        assertions = 0;
        failures   = 0;
        exp_n_seq   = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
        exp_m_seq   = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        exp_dn_seq  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        exp_dm_seq  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        exp_cfg_seq = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.N  = 4'd0;
        bus.M  = 2'd0;
        model_reset();
        #3;
        check_output();
        @(negedge clk_out);
        @(negedge clk_out);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Basic 4 x 2 frame from reset, with an independent table of the expected sequence.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, 4, 2);
            check_val("seq_N",   8'(bus.N_counter), 8'(exp_n_seq[i]));
            check_val("seq_M",   8'(bus.M_counter), 8'(exp_m_seq[i]));
            check_val("seq_DIVN", 8'(bus.DIV_N),    8'(exp_dn_seq[i]));
            check_val("seq_DIVM", 8'(bus.DIV_M),    8'(exp_dm_seq[i]));
            check_val("seq_cfg", 8'(bus.cfg_upd),   8'(exp_cfg_seq[i]));
        end

        // Ratio change mid-frame: N goes 4 -> 6 at (2,1) and only takes effect at the boundary.
        apply_stimulus(1'b1, 4, 2);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 6, 2);
        check_val("old_frame_DIVM", 8'(bus.DIV_M), 8'd1);
        check_val("old_frame_Nact", 8'(bus.N_act), 8'd4);
        apply_stimulus(1'b1, 6, 2);
        check_val("new_Nact", 8'(bus.N_act),   8'd6);
        check_val("new_cfg",  8'(bus.cfg_upd), 8'd1);
        for (int i = 0; i < 11; i++) apply_stimulus(1'b1, 6, 2);
        check_val("12cyc_DIVM", 8'(bus.DIV_M), 8'd1);
        apply_stimulus(1'b1, 6, 2);
        check_val("12cyc_wrapN", 8'(bus.N_counter), 8'd1);
        check_val("12cyc_nocfg", 8'(bus.cfg_upd),   8'd0);

        // N = 0, M = 0 sanitizes to 1 x 1: every cycle is a frame boundary.
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 0, 0);
            check_val("one_DIVN", 8'(bus.DIV_N),     8'd1);
            check_val("one_DIVM", 8'(bus.DIV_M),     8'd1);
            check_val("one_N",    8'(bus.N_counter), 8'd1);
        end

        // en dropped at (2,1) of a 3 x 3 frame: the frame still completes, then IDLE.
        apply_stimulus(1'b1, 3, 3);
        apply_stimulus(1'b1, 3, 3);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 3, 3);
        check_val("stop_last_DIVM", 8'(bus.DIV_M), 8'd1);
        apply_stimulus(1'b0, 3, 3);
        check_val("idle_N",    8'(bus.N_counter), 8'd0);
        check_val("idle_DIVN", 8'(bus.DIV_N),     8'd0);
        check_val("idle_cfg",  8'(bus.cfg_upd),   8'd0);
        check_val("idle_Nact", 8'(bus.N_act),     8'd3);
        apply_stimulus(1'b1, 3, 3);
        check_val("resume_N",   8'(bus.N_counter), 8'd1);
        check_val("resume_cfg", 8'(bus.cfg_upd),   8'd0);

        // en glitch low mid-frame is ignored.
        apply_stimulus(1'b0, 3, 3);
        apply_stimulus(1'b1, 3, 3);
        check_val("glitch_N", 8'(bus.N_counter), 8'd3);

        // Async reset between edges at (3,2) of a 4 x 2 frame.
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 4, 2);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 4, 2);
        check_val("pre_rst_N", 8'(bus.N_counter), 8'd3);
        check_val("pre_rst_M", 8'(bus.M_counter), 8'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        @(negedge clk_out);
        check_output();
        rst_n = 1'b1;

        // Randomized traffic with en mostly high so full frames and ratio changes dominate.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 8) != 0, int'($urandom % 16), int'($urandom % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
